axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter_if.sv | 32 +++
 rtl/axi_lite_arbiter.sv | 103 ++++++++++
 tb/tb_axi_lite_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// axi_lite_arbiter_if: one AXI4-Lite port (AW/W/B/AR/R) between a master and a slave
interface axi_lite_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin 2:1 AXI4-Lite arbiter, one transaction at a time
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi_lite_arbiter_if.slave  m0,
    axi_lite_arbiter_if.slave  m1,
    axi_lite_arbiter_if.master s,
    output logic               grant,
    output logic               busy
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;
    state_t state_q, state_d;
    logic grant_q, grant_d, last_q, last_d;
    logic req0, req1, pick;
    logic aw_on, w_on, b_on, ar_on, r_on;
    logic [ADDR_WIDTH-1:0] g_awaddr, g_araddr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [STRB_WIDTH-1:0] g_wstrb;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    assign req0 = m0.awvalid | m0.arvalid;
    assign req1 = m1.awvalid | m1.arvalid;
    // under contention the master that did not finish last wins
    assign pick = (req0 & req1) ? ~last_q : req1;
    assign aw_on = state_q == WADDR;
    assign w_on  = state_q == WDATA;
    assign b_on  = state_q == WRESP;
    assign ar_on = state_q == RADDR;
    assign r_on  = state_q == RDATA;
    assign g_awaddr  = grant_q ? m1.awaddr  : m0.awaddr;
    assign g_awvalid = grant_q ? m1.awvalid : m0.awvalid;
    assign g_wdata   = grant_q ? m1.wdata   : m0.wdata;
    assign g_wstrb   = grant_q ? m1.wstrb   : m0.wstrb;
    assign g_wvalid  = grant_q ? m1.wvalid  : m0.wvalid;
    assign g_bready  = grant_q ? m1.bready  : m0.bready;
    assign g_araddr  = grant_q ? m1.araddr  : m0.araddr;
    assign g_arvalid = grant_q ? m1.arvalid : m0.arvalid;
    assign g_rready  = grant_q ? m1.rready  : m0.rready;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                grant_d = pick;
                state_d = (pick ? m1.awvalid : m0.awvalid) ? WADDR : RADDR;
            end
            WADDR: state_d = (g_awvalid & s.awready) ? WDATA : WADDR;
            WDATA: state_d = (g_wvalid & s.wready) ? WRESP : WDATA;
            WRESP: if (s.bvalid & g_bready) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            RADDR: state_d = (g_arvalid & s.arready) ? RDATA : RADDR;
            RDATA: if (s.rvalid & g_rready) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end
    assign s.awaddr  = aw_on ? g_awaddr : '0;
    assign s.awvalid = aw_on & g_awvalid;
    assign s.wdata   = w_on ? g_wdata : '0;
    assign s.wstrb   = w_on ? g_wstrb : '0;
    assign s.wvalid  = w_on & g_wvalid;
    assign s.bready  = b_on & g_bready;
    assign s.araddr  = ar_on ? g_araddr : '0;
    assign s.arvalid = ar_on & g_arvalid;
    assign s.rready  = r_on & g_rready;
    assign m0.awready = aw_on & ~grant_q & s.awready;
    assign m0.wready  = w_on & ~grant_q & s.wready;
    assign m0.bvalid  = b_on & ~grant_q & s.bvalid;
    assign m0.bresp   = (b_on & ~grant_q) ? s.bresp : 2'b00;
    assign m0.arready = ar_on & ~grant_q & s.arready;
    assign m0.rvalid  = r_on & ~grant_q & s.rvalid;
    assign m0.rdata   = (r_on & ~grant_q) ? s.rdata : '0;
    assign m0.rresp   = (r_on & ~grant_q) ? s.rresp : 2'b00;
    assign m1.awready = aw_on & grant_q & s.awready;
    assign m1.wready  = w_on & grant_q & s.wready;
    assign m1.bvalid  = b_on & grant_q & s.bvalid;
    assign m1.bresp   = (b_on & grant_q) ? s.bresp : 2'b00;
    assign m1.arready = ar_on & grant_q & s.arready;
    assign m1.rvalid  = r_on & grant_q & s.rvalid;
    assign m1.rdata   = (r_on & grant_q) ? s.rdata : '0;
    assign m1.rresp   = (r_on & grant_q) ? s.rresp : 2'b00;
    assign grant = grant_q;
    assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed scenarios for the 2:1 AXI4-Lite arbiter
module tb_axi_lite_arbiter;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic grant, busy;
    int checks = 0;
    int failures = 0;
    axi_lite_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) mi0 ();
    axi_lite_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) mi1 ();
    axi_lite_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) si ();
    axi_lite_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .m0(mi0), .m1(mi1), .s(si), .grant(grant), .busy(busy)
    );
    always #5 ACLK = ~ACLK;

    task automatic test_reset;
        repeat (2) @(negedge ACLK);
        mi0.arvalid = 1'b1;
        mi1.awvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.awvalid, si.arvalid, si.wvalid, si.bready, si.rready, mi0.arready, mi1.awready, mi0.rvalid, mi1.bvalid} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b expected 0", {busy, grant, si.awvalid, si.arvalid, si.wvalid, si.bready, si.rready, mi0.arready, mi1.awready, mi0.rvalid, mi1.bvalid});
        end
        checks++;
        if (si.araddr !== 12'h000) begin failures++; $display("FAIL reset_araddr got %h expected 000", si.araddr); end
        mi0.arvalid = 1'b0;
        mi1.awvalid = 1'b0;
        ARESET = 1'b0;
    endtask

    task automatic test_read_rr;
        @(negedge ACLK);
        mi0.araddr = 12'h004; mi0.arvalid = 1'b1;
        mi1.araddr = 12'h014; mi1.arvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.arvalid, mi0.arready, mi1.arready} !== 5'b10110) begin failures++; $display("FAIL rr_first_grant got %b expected 10110", {busy, grant, si.arvalid, mi0.arready, mi1.arready}); end
        checks++;
        if (si.araddr !== 12'h004) begin failures++; $display("FAIL rr_first_addr got %h expected 004", si.araddr); end
        @(negedge ACLK);
        mi0.arvalid = 1'b0;
        checks++;
        if ({mi0.rvalid, mi1.rvalid, si.rready, si.arvalid, mi0.rdata} !== {4'b1010, 8'h3C}) begin failures++; $display("FAIL rr_first_rdata got %h expected a3c", {mi0.rvalid, mi1.rvalid, si.rready, si.arvalid, mi0.rdata}); end
        @(negedge ACLK);
        checks++;
        if ({busy, si.arvalid, si.araddr} !== 14'h0) begin failures++; $display("FAIL rr_idle_gap got %h expected 0", {busy, si.arvalid, si.araddr}); end
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.arvalid, si.araddr} !== {3'b111, 12'h014}) begin failures++; $display("FAIL rr_second_grant got %h expected 7014", {busy, grant, si.arvalid, si.araddr}); end
        @(negedge ACLK);
        mi1.arvalid = 1'b0;
        checks++;
        if ({mi1.rvalid, mi0.rvalid} !== 2'b10) begin failures++; $display("FAIL rr_second_rvalid got %b expected 10", {mi1.rvalid, mi0.rvalid}); end
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rr_end_idle got %b expected 0", busy); end
    endtask

    task automatic test_write;
        @(negedge ACLK);
        mi0.awaddr = 12'h004; mi0.awvalid = 1'b1;
        mi0.wdata = 8'hA5; mi0.wstrb = 1'b1; mi0.wvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.awvalid, si.wvalid, mi0.bvalid, mi0.awready, mi0.wready} !== 7'b1010010) begin failures++; $display("FAIL wr_waddr got %b expected 1010010", {busy, grant, si.awvalid, si.wvalid, mi0.bvalid, mi0.awready, mi0.wready}); end
        checks++;
        if ({si.awaddr, si.wdata} !== {12'h004, 8'h00}) begin failures++; $display("FAIL wr_waddr_bus got %h expected 00400", {si.awaddr, si.wdata}); end
        @(negedge ACLK);
        mi0.awvalid = 1'b0;
        checks++;
        if ({si.awvalid, si.wvalid, mi0.bvalid, mi0.wready} !== 4'b0101) begin failures++; $display("FAIL wr_wdata got %b expected 0101", {si.awvalid, si.wvalid, mi0.bvalid, mi0.wready}); end
        checks++;
        if ({si.awaddr, si.wdata, si.wstrb} !== {12'h000, 8'hA5, 1'b1}) begin failures++; $display("FAIL wr_wdata_bus got %h expected 0014b", {si.awaddr, si.wdata, si.wstrb}); end
        @(negedge ACLK);
        mi0.wvalid = 1'b0;
        checks++;
        if ({si.awvalid, si.wvalid, mi0.bvalid, si.bready, mi1.bvalid, mi0.bresp} !== 7'b0011000) begin failures++; $display("FAIL wr_wresp got %b expected 0011000", {si.awvalid, si.wvalid, mi0.bvalid, si.bready, mi1.bvalid, mi0.bresp}); end
        @(negedge ACLK);
        checks++;
        if ({busy, mi0.bvalid, si.bready} !== 3'b000) begin failures++; $display("FAIL wr_done got %b expected 000", {busy, mi0.bvalid, si.bready}); end
    endtask

    task automatic test_write_then_read;
        si.bresp = 2'b11;
        @(negedge ACLK);
        mi1.awaddr = 12'h020; mi1.awvalid = 1'b1;
        mi1.wdata = 8'h5A; mi1.wstrb = 1'b1; mi1.wvalid = 1'b1;
        mi1.araddr = 12'h030; mi1.arvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.awvalid, si.arvalid, si.awaddr} !== {4'b1110, 12'h020}) begin failures++; $display("FAIL wtr_write_first got %h expected e020", {busy, grant, si.awvalid, si.arvalid, si.awaddr}); end
        @(negedge ACLK);
        mi1.awvalid = 1'b0;
        checks++;
        if ({si.wvalid, si.wdata} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL wtr_wdata got %h expected 15a", {si.wvalid, si.wdata}); end
        @(negedge ACLK);
        mi1.wvalid = 1'b0;
        checks++;
        if ({mi1.bvalid, mi1.bresp, si.arvalid, mi0.bvalid} !== 5'b11100) begin failures++; $display("FAIL wtr_bresp got %b expected 11100", {mi1.bvalid, mi1.bresp, si.arvalid, mi0.bvalid}); end
        @(negedge ACLK);
        checks++;
        if ({busy, si.arvalid} !== 2'b00) begin failures++; $display("FAIL wtr_idle_gap got %b expected 00", {busy, si.arvalid}); end
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.arvalid, si.araddr} !== {3'b111, 12'h030}) begin failures++; $display("FAIL wtr_read_grant got %h expected 7030", {busy, grant, si.arvalid, si.araddr}); end
        @(negedge ACLK);
        mi1.arvalid = 1'b0;
        checks++;
        if (mi1.rvalid !== 1'b1) begin failures++; $display("FAIL wtr_rvalid got %b expected 1", mi1.rvalid); end
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL wtr_end_idle got %b expected 0", busy); end
        si.bresp = 2'b00;
    endtask

    task automatic test_read_stall;
        si.rresp = 2'b10;
        mi0.rready = 1'b0;
        @(negedge ACLK);
        mi0.araddr = 12'h008; mi0.arvalid = 1'b1;
        mi1.araddr = 12'h014; mi1.arvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.arvalid, si.araddr} !== {3'b101, 12'h008}) begin failures++; $display("FAIL stall_grant got %h expected 5008", {busy, grant, si.arvalid, si.araddr}); end
        @(negedge ACLK);
        mi0.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge ACLK);
            checks++;
            if ({busy, grant, mi0.rvalid, mi0.rresp, si.rready, mi1.arready, si.arvalid} !== 8'b10110000) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got %b expected 10110000", k, {busy, grant, mi0.rvalid, mi0.rresp, si.rready, mi1.arready, si.arvalid});
            end
        end
        mi0.rready = 1'b1;
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL stall_release got %b expected 0", busy); end
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.arvalid, si.araddr} !== {3'b111, 12'h014}) begin failures++; $display("FAIL stall_m1_grant got %h expected 7014", {busy, grant, si.arvalid, si.araddr}); end
        @(negedge ACLK);
        mi1.arvalid = 1'b0;
        checks++;
        if ({mi1.rvalid, mi1.rresp} !== 3'b110) begin failures++; $display("FAIL stall_m1_rresp got %b expected 110", {mi1.rvalid, mi1.rresp}); end
        @(negedge ACLK);
        si.rresp = 2'b00;
    endtask

    task automatic test_async_reset;
        @(negedge ACLK);
        mi1.awaddr = 12'h040; mi1.awvalid = 1'b1;
        mi1.wdata = 8'h77; mi1.wstrb = 1'b1; mi1.wvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.awvalid} !== 3'b111) begin failures++; $display("FAIL arst_waddr got %b expected 111", {busy, grant, si.awvalid}); end
        @(negedge ACLK);
        mi1.awvalid = 1'b0;
        checks++;
        if (si.wvalid !== 1'b1) begin failures++; $display("FAIL arst_wdata got %b expected 1", si.wvalid); end
        #1 ARESET = 1'b1;
        #1;
        checks++;
        if ({busy, grant, si.wvalid, mi1.wready, si.awvalid, si.wdata} !== 13'h0) begin failures++; $display("FAIL arst_immediate got %h expected 0", {busy, grant, si.wvalid, mi1.wready, si.awvalid, si.wdata}); end
        mi1.wvalid = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        mi0.araddr = 12'h004; mi0.arvalid = 1'b1;
        mi1.araddr = 12'h014; mi1.arvalid = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({busy, grant, si.araddr} !== {2'b10, 12'h004}) begin failures++; $display("FAIL arst_next_grant got %h expected 2004", {busy, grant, si.araddr}); end
        mi0.arvalid = 1'b0;
        mi1.arvalid = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    initial begin
        mi0.awaddr = '0; mi0.awvalid = 0; mi0.wdata = '0; mi0.wstrb = '0; mi0.wvalid = 0;
        mi0.bready = 1; mi0.araddr = '0; mi0.arvalid = 0; mi0.rready = 1;
        mi1.awaddr = '0; mi1.awvalid = 0; mi1.wdata = '0; mi1.wstrb = '0; mi1.wvalid = 0;
        mi1.bready = 1; mi1.araddr = '0; mi1.arvalid = 0; mi1.rready = 1;
        si.awready = 1; si.wready = 1; si.bresp = 2'b00; si.bvalid = 1;
        si.arready = 1; si.rdata = 8'h3C; si.rresp = 2'b00; si.rvalid = 1;
        test_reset();
        test_read_rr();
        test_write();
        test_write_then_read();
        test_read_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
